// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with a per-grant hold limit and a
// mandatory one-cycle turnaround between grants.
module rr_arbiter8 #(
  parameter int HOLD_W   = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [2:0]        ptr_reg, ptr_next;
  logic [2:0]        gnt_idx_reg, gnt_idx_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic              timeout_reg, timeout_next;

  logic [2:0]        win_idx;
  logic              win_found;
  logic [2:0]        cand;
  logic              limit_hit;

  // First requester at or above ptr, wrapping 7 -> 0.
  always_comb begin
    win_idx   = 3'd0;
    win_found = 1'b0;
    cand      = 3'd0;
    for (int k = 0; k < 8; k++) begin
      cand = ptr_reg + 3'(k);
      if (!win_found && req[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end

  // The counter reads MAX_HOLD-1 during the last permitted grant cycle.
  assign limit_hit = (MAX_HOLD != 0) && (hold_cnt_reg == HOLD_W'(MAX_HOLD - 1));

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    gnt_idx_next  = gnt_idx_reg;
    hold_cnt_next = hold_cnt_reg;
    timeout_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (en && win_found) begin
          state_next    = GRANT;
          gnt_idx_next  = win_idx;
          ptr_next      = win_idx + 3'd1;
          hold_cnt_next = '0;
        end
      end
      GRANT: begin
        hold_cnt_next = (&hold_cnt_reg) ? hold_cnt_reg : hold_cnt_reg + 1'b1;
        if (!req[gnt_idx_reg]) begin
          state_next   = IDLE;
          gnt_idx_next = 3'd0;
        end else if (limit_hit) begin
          state_next   = IDLE;
          gnt_idx_next = 3'd0;
          timeout_next = 1'b1;
        end
      end
      default: begin
        state_next   = IDLE;
        gnt_idx_next = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      ptr_reg      <= 3'd0;
      gnt_idx_reg  <= 3'd0;
      hold_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      gnt_idx_reg  <= gnt_idx_next;
      hold_cnt_reg <= hold_cnt_next;
      timeout_reg  <= timeout_next;
    end
  end

  assign busy    = (state_reg == GRANT);
  assign gnt_idx = gnt_idx_reg;
  assign timeout = timeout_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_decode
      assign gnt[gi] = busy && (gnt_idx_reg == 3'(gi));
    end
  endgenerate

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Eight-way round-robin arbiter that shares one resource (bus, register bank, output port) among eight requesters. It returns the winner both as a 3-bit index and as the one-hot 8-bit select produced by 3-to-8 decoding of that index. Each grant is held for as long as the winner keeps requesting, up to a programmable hold limit. A mandatory one-cycle turnaround follows every grant. The block sits between the requesters and the resource's select lines.

## Interface
Parameters:
- HOLD_W, 8, width of the hold counter.
- MAX_HOLD, 16, maximum cycles per grant; 0 = unlimited. Legal range 0..2^HOLD_W-1.

Ports (clock is `clk`, reset is `rst_n`: one clock, asynchronous active-low reset):
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  arbitration enable; low blocks new grants only.
- req  input  8  request per requester; bit i = requester i.
- gnt  output  8  one-hot grant; all zero when nothing is granted.
- gnt_idx  output  3  binary index of the granted requester; 0 when idle.
- busy  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse when a grant is force-released at MAX_HOLD.

## Operation
- Two states: IDLE and GRANT.
- IDLE:
  - If en=1 and req!=0, pick the winner.
  - The winner is the first set bit of req, scanning upward from ptr and wrapping 7→0.
  - Register the winner into gnt_idx, set gnt = decode(gnt_idx), go to GRANT, clear hold_cnt.
  - Otherwise stay in IDLE with gnt=0.
- GRANT:
  - hold_cnt increments each cycle, saturating at all-ones.
  - Release when req[gnt_idx]=0, or when MAX_HOLD!=0 and hold_cnt reaches MAX_HOLD-1. Release means next state IDLE, gnt=0, gnt_idx=0.
  - A forced release (timeout) with req still high pulses timeout for one cycle, aligned with the cycle gnt drops to 0.
  - If the request drops in the same cycle the limit is hit, it is a normal release: no timeout pulse.
- Priority pointer ptr (3 bits, internal):
  - On every grant to index i, ptr <= i+1 mod 8 (7 wraps to 0).
  - ptr changes only when a grant is issued.
- en=0 during GRANT has no effect on the current grant; it only prevents the next grant from IDLE.
- Requests that change while a grant is active are ignored until the next IDLE evaluation.
- gnt is always exactly decode(gnt_idx) while busy=1, and all-zero while busy=0. There is never more than one bit set.
- busy = (state == GRANT).

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE, ptr=0, hold_cnt=0, gnt=8'h00, gnt_idx=3'd0, busy=0, timeout=0.
- Grant latency:
  - req sampled high at edge k (state IDLE, en=1) gives gnt valid after edge k.
  - That is one cycle from the request being visible to the grant.
- Hold:
  - With MAX_HOLD=M>0 and req held, gnt stays high for exactly M cycles.
  - gnt is then low for exactly 1 cycle (turnaround), then the next winner is granted.
- Normal release: req[gnt_idx] sampled low at edge k means gnt=0 after edge k.
- Back-to-back: the minimum period between successive grants is one grant cycle plus one idle cycle. No requester gets two consecutive grants while another requester is waiting.
- Reset mid-grant: outputs clear immediately, asynchronously. After reset, arbitration restarts from ptr=0.

## Test plan
- Reset: assert rst_n=0 mid-grant with req=8'hFF → gnt=8'h00, gnt_idx=0, busy=0 immediately. After release, the first grant is gnt=8'h01.
- Rotation: req=8'hFF constant, MAX_HOLD=2 → grant order 0,1,2,…,7,0. Each grant lasts 2 cycles, followed by 1 idle cycle. timeout pulses after every grant.
- Skip and wrap:
  - req=8'h82 from reset, each requester drops req after 3 granted cycles → grants 1 then 7.
  - Then raise req=8'h03 → grant 0 (pointer wrapped from 7), then 1.
- Unlimited hold: MAX_HOLD=0, req[4] held for 300 cycles → gnt=8'h10 for 300 cycles, no timeout. hold_cnt saturates without release.
- Enable gating:
  - en=0 with req=8'h08 → no grant.
  - en→1 → gnt=8'h08 after one edge.
  - Drop en during that grant → grant persists until req[3] falls.
- Simultaneous drop at limit: MAX_HOLD=4, req[2] falls in the 4th grant cycle → gnt=0 next cycle and timeout stays 0.
